// File: rtl/vga_timing_sink.sv
// rtl/vga_timing_sink.sv - 640x480@60 VGA timing sink for the frame buffer read port
module vga_timing_sink #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int PIPE_LAT  = 2
) (
    input  logic        rd_clk,
    input  logic        rst,
    input  logic [11:0] pixel_in,
    input  logic        image_end,
    output logic        ready,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        vga_sync_n,
    output logic        frame_done,
    output logic        frame_err
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS      = HW'(H_VISIBLE);
    localparam logic [HW-1:0] H_VIS_LAST = HW'(H_VISIBLE - 1);
    localparam logic [HW-1:0] HS_BEG     = HW'(H_VISIBLE + H_FP);
    localparam logic [HW-1:0] HS_END     = HW'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS      = VW'(V_VISIBLE);
    localparam logic [VW-1:0] V_VIS_LAST = VW'(V_VISIBLE - 1);
    localparam logic [VW-1:0] VS_BEG     = VW'(V_VISIBLE + V_FP);
    localparam logic [VW-1:0] VS_END     = VW'(V_VISIBLE + V_FP + V_SYNC);

    logic [HW-1:0]       h_cnt_q, h_cnt_d;
    logic [VW-1:0]       v_cnt_q, v_cnt_d;
    logic [PIPE_LAT-1:0] vis_pipe_q, vis_pipe_d;
    logic [PIPE_LAT-1:0] hs_pipe_q, hs_pipe_d;
    logic [PIPE_LAT-1:0] vs_pipe_q, vs_pipe_d;
    logic [7:0]          r_q, r_d, g_q, g_d, b_q, b_d;
    logic                hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
    logic                seen_end_q, seen_end_d;
    logic                frame_err_q, frame_err_d;

    logic vis, hs_n, vs_n, frame_check, vis_dly;

    always_comb begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        end
    end

    always_comb begin
        vis         = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
        hs_n        = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
        vs_n        = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
        frame_check = (h_cnt_q == '0) && (v_cnt_q == V_VIS);
    end

    // Decode bits travel alongside the buffer's read latency so sync and data line up.
    always_comb begin
        vis_pipe_d    = vis_pipe_q;
        hs_pipe_d     = hs_pipe_q;
        vs_pipe_d     = vs_pipe_q;
        vis_pipe_d[0] = vis;
        hs_pipe_d[0]  = hs_n;
        vs_pipe_d[0]  = vs_n;
        for (int i = 1; i < PIPE_LAT; i++) begin
            vis_pipe_d[i] = vis_pipe_q[i-1];
            hs_pipe_d[i]  = hs_pipe_q[i-1];
            vs_pipe_d[i]  = vs_pipe_q[i-1];
        end
    end

    always_comb begin
        vis_dly   = vis_pipe_q[PIPE_LAT-1];
        r_d       = 8'h00;
        g_d       = 8'h00;
        b_d       = 8'h00;
        if (vis_dly) begin
            r_d = {pixel_in[11:8], pixel_in[11:8]};
            g_d = {pixel_in[7:4],  pixel_in[7:4]};
            b_d = {pixel_in[3:0],  pixel_in[3:0]};
        end
        hs_d      = hs_pipe_q[PIPE_LAT-1];
        vs_d      = vs_pipe_q[PIPE_LAT-1];
        blank_n_d = vis_dly;
    end

    // A frame is aligned only if the buffer flagged its last pixel during the visible lines.
    always_comb begin
        seen_end_d  = seen_end_q;
        frame_err_d = frame_err_q;
        if (image_end && (v_cnt_q < V_VIS)) begin
            seen_end_d = 1'b1;
        end
        if (frame_check) begin
            if (!seen_end_q) begin
                frame_err_d = 1'b1;
            end
            seen_end_d = 1'b0;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            vis_pipe_q  <= '0;
            hs_pipe_q   <= '1;
            vs_pipe_q   <= '1;
            r_q         <= 8'h00;
            g_q         <= 8'h00;
            b_q         <= 8'h00;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            blank_n_q   <= 1'b0;
            seen_end_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            vis_pipe_q  <= vis_pipe_d;
            hs_pipe_q   <= hs_pipe_d;
            vs_pipe_q   <= vs_pipe_d;
            r_q         <= r_d;
            g_q         <= g_d;
            b_q         <= b_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            blank_n_q   <= blank_n_d;
            seen_end_q  <= seen_end_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign ready       = vis && !rst;
    assign frame_done  = !rst && (h_cnt_q == H_VIS_LAST) && (v_cnt_q == V_VIS_LAST);
    assign vga_r       = r_q;
    assign vga_g       = g_q;
    assign vga_b       = b_q;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_blank_n = blank_n_q;
    assign vga_sync_n  = 1'b0;
    assign frame_err   = frame_err_q;
endmodule

// File: tb/tb_vga_timing_sink.sv
// tb/tb_vga_timing_sink.sv - scoreboard bench for vga_timing_sink on a shrunken raster
module tb_vga_timing_sink;
    localparam int HV = 8, HF = 2, HS = 3, HB = 2, HT = HV + HF + HS + HB;
    localparam int VV = 4, VF = 1, VS = 2, VB = 1, VT = VV + VF + VS + VB;
    localparam int PL = 2;
    localparam int FRAME = HT * VT;
    localparam int MAXC = 2048;

    logic        rd_clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] pixel_in = 12'h000;
    logic        image_end = 1'b0;
    logic        ready;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_done, frame_err;

    vga_timing_sink #(
        .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .PIPE_LAT(PL)
    ) dut (
        .rd_clk(rd_clk), .rst(rst), .pixel_in(pixel_in), .image_end(image_end),
        .ready(ready), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
        .vga_sync_n(vga_sync_n), .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 rd_clk = ~rd_clk;

    typedef struct packed {
        logic       rdy;
        logic [7:0] r, g, b;
        logic       hs, vs, bn, fd, err, sn;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_fail = 0;
    bit   drv_done = 0;

    // Phases: reset cycles, length, pixel mode (0 ramp, 1 F0A, 2 FFF, 3 random), image_end pulsing.
    int ph_rst[5] = '{3, 0, 2, 0, 1};
    int ph_len[5] = '{243, 120, 362, 35, 241};
    int ph_pix[5] = '{0, 1, 2, 3, 0};
    int ph_ie[5]  = '{0, 1, 1, 1, 1};
    int ph_begin[5];
    int ph_rel[5];

    bit         h_rst[MAXC], h_vis[MAXC], h_hs[MAXC], h_vs[MAXC];
    logic [11:0] h_pix[MAXC];
    int         h_idx[MAXC];
    bit         o_rdy[MAXC], o_hs[MAXC], o_vs[MAXC], o_bn[MAXC], o_fd[MAXC], o_err[MAXC];
    logic [7:0] o_r[MAXC], o_g[MAXC], o_b[MAXC];

    task automatic check(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    initial begin : drive
        int cyc, mh, mv, rcount, j;
        bit seen, err, vis, blank;
        exp_t e;
        logic [11:0] p;
        cyc = 0; mh = 0; mv = 0; rcount = 0; seen = 0; err = 0;
        for (int ph = 0; ph < 5; ph++) begin
            ph_begin[ph] = cyc;
            for (int i = 0; i < ph_len[ph]; i++) begin
                @(posedge rd_clk);
                #2;
                rst = (i < ph_rst[ph]);
                if (i == ph_rst[ph]) ph_rel[ph] = cyc;
                vis = !rst && (mh < HV) && (mv < VV);
                case (ph_pix[ph])
                    0: pixel_in = (cyc >= 2 && h_vis[cyc-2]) ? 12'(h_idx[cyc-2]) : 12'h000;
                    1: pixel_in = 12'hF0A;
                    2: pixel_in = 12'hFFF;
                    default: pixel_in = 12'($urandom);
                endcase
                image_end = (ph_ie[ph] != 0) && !rst && (mh == HV - 1) && (mv == VV - 1);
                h_rst[cyc] = rst;
                h_vis[cyc] = vis;
                h_hs[cyc]  = !((mh >= HV + HF) && (mh < HV + HF + HS));
                h_vs[cyc]  = !((mv >= VV + VF) && (mv < VV + VF + VS));
                h_pix[cyc] = pixel_in;
                h_idx[cyc] = rcount;

                e = '0;
                e.rdy = vis;
                e.fd  = !rst && (mh == HV - 1) && (mv == VV - 1);
                e.err = err;
                j = cyc - 1 - PL;
                blank = 0;
                for (int k = j; k < cyc; k++) if (k < 0 || h_rst[k]) blank = 1;
                if (blank) begin
                    e.hs = 1'b1; e.vs = 1'b1; e.bn = 1'b0;
                end else begin
                    e.hs = h_hs[j]; e.vs = h_vs[j]; e.bn = h_vis[j];
                    if (h_vis[j]) begin
                        p = h_pix[cyc-1];
                        e.r = {p[11:8], p[11:8]};
                        e.g = {p[7:4], p[7:4]};
                        e.b = {p[3:0], p[3:0]};
                    end
                end
                sb_q.push_back(e);

                if (rst) begin
                    mh = 0; mv = 0; seen = 0; err = 0; rcount = 0;
                end else begin
                    if (mv < VV && image_end) seen = 1;
                    if (mh == 0 && mv == VV) begin
                        if (!seen) err = 1;
                        seen = 0;
                    end
                    if (vis) rcount++;
                    if (mh == HT - 1) begin
                        mh = 0;
                        mv = (mv == VT - 1) ? 0 : mv + 1;
                    end else begin
                        mh++;
                    end
                end
                cyc++;
            end
        end
        @(posedge rd_clk);
        drv_done = 1;
    end

    initial begin : monitor
        int c, idle, cnt, r0, w0, last_fd, n_fd;
        exp_t e, g;
        c = 0; idle = 0;
        forever begin
            @(negedge rd_clk);
            if (sb_q.size() == 0) begin
                if (drv_done) break;
                idle++;
                if (idle > 20) begin
                    n_vec++; n_fail++;
                    $display("FAIL scoreboard_timeout: got no expected entries for %0d cycles, required activity", idle);
                    break;
                end
                continue;
            end
            idle = 0;
            e = sb_q.pop_front();
            g = {ready, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, frame_done, frame_err, vga_sync_n};
            o_rdy[c] = ready; o_hs[c] = vga_hs; o_vs[c] = vga_vs; o_bn[c] = vga_blank_n;
            o_fd[c] = frame_done; o_err[c] = frame_err;
            o_r[c] = vga_r; o_g[c] = vga_g; o_b[c] = vga_b;
            n_vec++;
            if (g !== e) begin
                n_fail++;
                if (n_fail < 30)
                    $display("FAIL cyc%0d outputs: got rdy=%b rgb=%h_%h_%h hs=%b vs=%b bn=%b fd=%b err=%b sn=%b, expected rdy=%b rgb=%h_%h_%h hs=%b vs=%b bn=%b fd=%b err=%b sn=%b",
                             c, g.rdy, g.r, g.g, g.b, g.hs, g.vs, g.bn, g.fd, g.err, g.sn,
                             e.rdy, e.r, e.g, e.b, e.hs, e.vs, e.bn, e.fd, e.err, e.sn);
            end
            c++;
        end

        // Reset state while rst is held.
        check("reset_ready", int'(o_rdy[0]), 0);
        check("reset_blank_n", int'(o_bn[0]), 0);
        check("reset_hs", int'(o_hs[0]), 1);

        // First visible output appears PL+1 cycles after release and carries pixel 0.
        r0 = ph_rel[0];
        check("first_vis_prev_blank_n", int'(o_bn[r0+2]), 0);
        check("first_vis_blank_n", int'(o_bn[r0+3]), 1);
        check("first_vis_pixel0", int'(o_r[r0+3]), 0);
        check("ready_after_release", int'(o_rdy[r0]), 1);

        // Missing image_end flags the frame at (0,VV); stays sticky through good frames.
        check("err_before_check", int'(o_err[r0 + VV*HT]), 0);
        check("err_after_check", int'(o_err[r0 + VV*HT + 1]), 1);
        check("err_sticky", int'(o_err[ph_begin[2]-1]), 1);

        r0 = ph_rel[1];
        check("f0a_r", int'(o_r[r0+3]), 8'hFF);
        check("f0a_g", int'(o_g[r0+3]), 8'h00);
        check("f0a_b", int'(o_b[r0+3]), 8'hAA);

        // Three free-running frames after a reset: handshake and sync widths.
        r0 = ph_rel[2];
        w0 = r0 + PL + 1;
        cnt = 0; for (int k = r0; k < r0 + 3*FRAME; k++) cnt += int'(o_rdy[k]);
        check("ready_high_3frames", cnt, 3*HV*VV);
        cnt = 0; for (int k = w0; k < w0 + 3*FRAME; k++) cnt += int'(!o_hs[k]);
        check("hs_low_3frames", cnt, 3*VT*HS);
        cnt = 0; for (int k = w0; k < w0 + 3*FRAME; k++) cnt += int'(!o_vs[k]);
        check("vs_low_3frames", cnt, 3*VS*HT);
        cnt = 0; for (int k = w0; k < w0 + 3*FRAME; k++) cnt += int'(o_bn[k]);
        check("blank_n_high_3frames", cnt, 3*HV*VV);
        n_fd = 0; last_fd = -1;
        for (int k = r0; k < r0 + 3*FRAME; k++) begin
            if (o_fd[k]) begin
                if (last_fd >= 0) check("frame_period", k - last_fd, FRAME);
                last_fd = k;
                n_fd++;
            end
        end
        check("frame_done_count", n_fd, 3);
        check("err_clean_frames", int'(o_err[ph_begin[3]-1]), 0);

        // Single-cycle reset mid-frame.
        r0 = ph_begin[4];
        check("midrst_ready_low", int'(o_rdy[r0]), 0);
        check("midrst_next_blank_n", int'(o_bn[r0+1]), 0);
        check("midrst_next_hs", int'(o_hs[r0+1]), 1);
        check("midrst_next_r", int'(o_r[r0+1]), 0);
        check("midrst_restart_ready", int'(o_rdy[r0+1]), 1);
        check("midrst_first_vis", int'(o_bn[r0+1+PL+1]), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
